// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES byte-stream controller.
//   state_t : controller state encoding (IDLE -> LOAD -> STREAM -> IDLE)
//   BYTE_W  : width of key/data bytes and of the core counter
package aes_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Requester-side bundle of the AES stream controller.
//   req_start/req_key          : message request and per-requester key
//   in_valid/in_data/in_last   : requester byte stream, in_ready back-pressure
//   gnt                        : one-hot grant pulse in the LOAD cycle
//   out_valid/out_data/out_last: registered result, out_data shared
// master = requester side, slave = controller side.
interface aes_stream_ctrl_if
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]        req_start;
    logic [N_REQ*BYTE_W-1:0] req_key;
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ*BYTE_W-1:0] in_data;
    logic [N_REQ-1:0]        in_last;
    logic [N_REQ-1:0]        in_ready;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        out_valid;
    logic [BYTE_W-1:0]       out_data;
    logic                    out_last;

    modport master (
        output req_start, req_key, in_valid, in_data, in_last,
        input  in_ready, gnt, out_valid, out_data, out_last
    );

    modport slave (
        input  req_start, req_key, in_valid, in_data, in_last,
        output in_ready, gnt, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index with highest priority this round
//   win : one-hot winner, the first set request at or after ptr (wrapping)
//   any : at least one request is set
module aes_rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         win,
    output logic                     any
);
    localparam int unsigned PW = $clog2(N_REQ);
    localparam logic [PW:0] NUM = (PW + 1)'(N_REQ);

    always_comb begin : p_arb
        logic [PW:0] pos;
        win = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit so ptr + i can wrap for non power-of-two N_REQ.
            pos = {1'b0, ptr} + (PW + 1)'(i);
            if (pos >= NUM) begin
                pos = pos - NUM;
            end
            if (!any && req[pos[PW-1:0]]) begin
                win[pos[PW-1:0]] = 1'b1;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/aes_stream_ctrl.sv
// Shares one AES_cipher byte-stream core between N_REQ requesters.
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus            : requester bundle (aes_stream_ctrl_if.slave)
//   cph_new_message, cph_key, cph_data_in, cph_valid_in : drive the core
//   cph_data_out, cph_valid_out                         : from the core
// The core counter free-runs every cycle, so a stall cycle re-seeds it with
// key_base + idx; the next accepted byte then lands on keystream position idx.
module aes_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    aes_stream_ctrl_if.slave  bus,
    output logic              cph_new_message,
    output logic [BYTE_W-1:0] cph_key,
    output logic [BYTE_W-1:0] cph_data_in,
    output logic              cph_valid_in,
    input  logic [BYTE_W-1:0] cph_data_out,
    input  logic              cph_valid_out
);
    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [BYTE_W-1:0] idx_q, idx_d;
    logic [BYTE_W-1:0] key_base_q, key_base_d;
    logic [N_REQ-1:0]  out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q;
    logic              out_last_q, out_last_d;

    logic [N_REQ-1:0]  win;
    logic              any;
    logic [PTR_W-1:0]  win_idx;
    logic [N_REQ-1:0]  ready_vec, gnt_vec;
    logic              own_valid, own_last, accept;
    logic [BYTE_W-1:0] own_data;

    aes_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req_start),
        .ptr (rr_ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    assign own_valid = bus.in_valid[owner_q];
    assign own_last  = bus.in_last[owner_q];
    assign own_data  = bus.in_data[BYTE_W*owner_q +: BYTE_W];
    assign accept    = (state_q == STREAM) && own_valid;

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        idx_d           = idx_q;
        key_base_d      = key_base_q;
        ready_vec       = '0;
        gnt_vec         = '0;
        cph_new_message = 1'b0;
        cph_key         = '0;
        cph_data_in     = '0;
        cph_valid_in    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    key_base_d = bus.req_key[BYTE_W*win_idx +: BYTE_W];
                    idx_d      = '0;
                    owner_d    = win_idx;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cph_new_message  = 1'b1;
                cph_key          = key_base_q;
                gnt_vec[owner_q] = 1'b1;
                state_d          = STREAM;
            end
            STREAM: begin
                ready_vec[owner_q] = 1'b1;
                if (own_valid) begin
                    cph_valid_in = 1'b1;
                    cph_data_in  = own_data;
                    idx_d        = idx_q + 8'd1;
                    if (own_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
                    end
                end else begin
                    // Re-seed so the counter sits on position idx next cycle.
                    cph_new_message = 1'b1;
                    cph_key         = key_base_q + idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid_d = cph_valid_out ? (N_REQ'(1) << owner_q) : '0;
    assign out_last_d  = accept & own_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            idx_q       <= '0;
            key_base_q  <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            idx_q       <= idx_d;
            key_base_q  <= key_base_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= cph_data_out;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.gnt       = gnt_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Message-level controller that shares one `AES_cipher` byte-stream core between `N_REQ` requesters. It grants one requester at a time by round-robin and loads that requester's key into the core. It streams the requester's bytes through the core and returns results to it. When the requester stalls mid-message it re-seeds the core counter, so the keystream never skips a position.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_start` in N_REQ: level request per requester. Held high until that requester's `gnt` bit pulses.
- `req_key` in N_REQ*8: per-requester message key, byte i at [8i+7:8i]. Sampled in the grant cycle.
- `in_valid` in N_REQ: requester byte valid.
- `in_data` in N_REQ*8: requester plaintext/ciphertext byte.
- `in_last` in N_REQ: marks the final byte of the message.
- `in_ready` out N_REQ: byte accepted when `in_valid & in_ready`.
- `gnt` out N_REQ: one-cycle pulse in the LOAD cycle, one-hot.
- `out_valid` out N_REQ: registered result valid, one-hot.
- `out_data` out 8: registered result byte, shared by all requesters.
- `out_last` out 1: registered, high together with the result of the `in_last` byte.
- `cph_new_message` out 1: drives core `new_message`.
- `cph_key` out 8: drives core `key`.
- `cph_data_in` out 8: drives core `data_in`.
- `cph_valid_in` out 1: drives core `valid_in`.
- `cph_data_out` in 8: from core `data_out`.
- `cph_valid_out` in 1: from core `valid_out`.

## Operation
- Core behaviour relied on:
  - `new_message` loads `key` into the counter at the clock edge.
  - In every other cycle the counter increments, whether or not a byte is valid.
  - `data_out = data_in ^ inv_sbox[counter]` combinationally while `valid_in` is high.
- State machine `IDLE -> LOAD -> STREAM -> IDLE`.
- IDLE
  - If any `req_start` is high, pick the winner by round-robin, starting from `rr_ptr`.
  - Capture `key_base <= req_key[winner]`, `idx <= 0`, `owner <= winner`, then go to LOAD.
- LOAD (1 cycle)
  - `cph_new_message = 1` and `cph_key = key_base`.
  - `gnt[owner] = 1`.
  - `in_ready = 0`.
  - Next state is STREAM.
- STREAM
  - `in_ready[owner] = 1`. All other `in_ready` bits are 0.
  - Byte accepted (`in_valid[owner]`):
    - `cph_valid_in = 1`, `cph_data_in = in_data[owner]`, `cph_new_message = 0`.
    - `idx <= idx + 1`.
  - Stall cycle (`in_valid[owner] = 0`):
    - `cph_new_message = 1`, `cph_key = key_base + idx + 1` (8-bit, mod 256). This re-seed is a hard requirement.
    - `idx` is not changed.
    - Next accepted byte still uses keystream position `idx`, because the counter restarts at `key_base + idx + 1`... see correction below.
    - Correction, binding: the stall re-seed key is `key_base + idx`. The counter equals `key_base + idx` in the cycle after the re-seed, which is exactly the position of the next byte.
  - Accepted byte with `in_last[owner]`: go to IDLE and set `rr_ptr <= owner + 1` (wrapping at `N_REQ`).
- Result register, updated every cycle:
  - `out_valid <= cph_valid_out ? onehot(owner) : 0`.
  - `out_data <= cph_data_out`.
  - `out_last <= accepted & in_last[owner]`.
- Arithmetic: `idx` and all key sums are 8-bit and wrap mod 256, matching the core counter. Message length is unbounded.
- `cph_*` outputs when not in LOAD or STREAM: `cph_new_message = 0`, `cph_valid_in = 0`, `cph_key = 0`, `cph_data_in = 0`.
- `req_start` of the owner is ignored until the controller returns to IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `rr_ptr = 0`, `idx = 0`, `key_base = 0`, `owner = 0`.
- Reset mid-message: abort immediately with no result for the byte in flight. After release the controller restarts in IDLE.
- Grant latency: `req_start` high in IDLE at cycle t gives LOAD and `gnt` at t+1, and first possible byte acceptance at t+2.
- Result latency: a byte accepted at cycle c appears on `out_data`/`out_valid` at c+1.
- Back-to-back messages: the minimum gap is 2 cycles, one in IDLE and one in LOAD.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins.
- Single-byte message: a `last` on the first byte is legal. The controller goes LOAD, STREAM (1 cycle), then IDLE.

## Structure
- Package `aes_ctrl_pkg`:
  - `state_t` enum {IDLE, LOAD, STREAM}.
  - `localparam BYTE_W = 8`.
- Sub-module `aes_rr_arbiter`:
  - Parameter `N_REQ`.
  - Inputs `req`, `ptr`.
  - Outputs one-hot `win` and `any`.
  - Purely combinational.
- The top level connects `cph_*` to an `AES_cipher` instance.

## Test plan
- Basic stream: req0, key 0x00, bytes 0x00,0x00,0x00 (last on the third) -> `out_data` 0x52,0x09,0x6a on `out_valid[0]`, and `out_last` with 0x6a.
- Stall re-seed: key 0x00, byte 0x00, two idle cycles, byte 0x00 (last) -> 0x52 then 0x09 (no skip). Check `cph_new_message`=1 with `cph_key`=0x01 during the stalls.
- Wrap: key 0xFF, bytes 0x00,0x00 -> 0x7d then 0x52.
- Arbitration: `req_start`=2'b11 from reset -> req0 served first, then req1 with key 0x01. Check req1's first output byte 0x00 -> 0x09 and `rr_ptr` = 0 afterwards.
- Round-robin fairness: req0 re-requests immediately after finishing while req1 is pending -> req1 is granted before req0.
- Reset mid-message: assert `reset_n`=0 during STREAM -> all outputs 0 asynchronously. After release a new req0 message with key 0x02, byte 0x00 -> 0x6a.
